// File: rtl/ofdm_subcarrier_demux_pkg.sv
// Shared OFDM constants and the 64-entry subcarrier class table
// (FFT-shifted order, index 32 = DC).
package ofdm_subcarrier_demux_pkg;

  localparam int unsigned N_SC    = 64;
  localparam int unsigned N_DATA  = 48;
  localparam int unsigned N_PILOT = 4;
  localparam int unsigned IDX_W   = $clog2(N_SC);

  localparam logic [IDX_W-1:0] LAST_DATA_IDX  = 6'd58;
  localparam logic [IDX_W-1:0] LAST_PILOT_IDX = 6'd53;
  localparam logic [IDX_W-1:0] LAST_SC_IDX    = 6'd63;

  typedef enum logic [1:0] {
    SC_NULL  = 2'd0,
    SC_DATA  = 2'd1,
    SC_PILOT = 2'd2
  } sc_class_e;

  function automatic sc_class_e sc_class(input logic [IDX_W-1:0] idx);
    sc_class_e c;
    case (idx)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5,
      6'd32,
      6'd59, 6'd60, 6'd61, 6'd62, 6'd63: c = SC_NULL;
      6'd11, 6'd25, 6'd39, 6'd53:        c = SC_PILOT;
      default:                           c = SC_DATA;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ofdm_subcarrier_demux_out_reg.sv
// One-deep valid/ready register stage carrying {tlast, tdata}.
module ofdm_out_reg #(
  parameter int unsigned W = 33
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/ofdm_subcarrier_demux.sv
// Splits a 64-beat equalized OFDM symbol into data and pilot streams,
// discarding null subcarriers and counting framing errors.
module ofdm_subcarrier_demux
  import ofdm_subcarrier_demux_pkg::*;
#(
  parameter bit DROP_PILOTS = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sof_i,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic [31:0] p_tdata,
  output logic        p_tlast,
  output logic        p_tvalid,
  input  logic        p_tready,
  output logic [7:0]  err_cnt_o
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] cur_idx;
  logic [7:0]       err_q;
  sc_class_e        cls;
  logic             d_in_ready, p_in_ready;
  logic             accept, d_load, p_load;
  logic             frame_err;

  assign cur_idx = sof_i ? '0 : idx_q;
  assign cls     = sc_class(cur_idx);

  always_comb begin
    i_tready = 1'b0;
    case (cls)
      SC_NULL:  i_tready = 1'b1;
      SC_DATA:  i_tready = d_in_ready;
      SC_PILOT: i_tready = DROP_PILOTS ? 1'b1 : p_in_ready;
      default:  i_tready = 1'b0;
    endcase
    // Reset gating keeps i_tready low even though the empty registers look ready.
    i_tready = i_tready && rst_ni;
  end

  assign accept = i_tvalid && i_tready;
  assign d_load = accept && (cls == SC_DATA);
  assign p_load = accept && (cls == SC_PILOT) && !DROP_PILOTS;

  assign frame_err = (i_tlast && (cur_idx != LAST_SC_IDX)) ||
                     (!i_tlast && (cur_idx == LAST_SC_IDX));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
      err_q <= '0;
    end else if (accept) begin
      if (i_tlast && (cur_idx != LAST_SC_IDX)) idx_q <= '0;
      else if (sof_i)                          idx_q <= 6'd1;
      else                                     idx_q <= cur_idx + 6'd1;
      if (frame_err && (err_q != '1)) err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt_o = err_q;

  ofdm_out_reg #(.W(33)) u_data_reg (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_data   ({cur_idx == LAST_DATA_IDX, i_tdata}),
    .in_valid  (d_load),
    .in_ready  (d_in_ready),
    .out_data  ({o_tlast, o_tdata}),
    .out_valid (o_tvalid),
    .out_ready (o_tready)
  );

  ofdm_out_reg #(.W(33)) u_pilot_reg (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_data   ({cur_idx == LAST_PILOT_IDX, i_tdata}),
    .in_valid  (p_load),
    .in_ready  (p_in_ready),
    .out_data  ({p_tlast, p_tdata}),
    .out_valid (p_tvalid),
    .out_ready (p_tready)
  );

endmodule

// File: tb/tb_ofdm_subcarrier_demux.sv
// Directed bench for ofdm_subcarrier_demux: queue-based reference model plus
// literal pins of the expected subcarrier sequences.
module tb_ofdm_subcarrier_demux;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        sof_i = 1'b0;
  logic [31:0] i_tdata = '0;
  logic        i_tlast = 1'b0, i_tvalid = 1'b0, i_tready;
  logic [31:0] o_tdata, p_tdata;
  logic        o_tlast, o_tvalid, p_tlast, p_tvalid;
  logic        o_tready = 1'b1, p_tready = 1'b1;
  logic [7:0]  err_cnt_o;

  logic        d1_sof = 1'b0;
  logic [31:0] d1_i_tdata = '0;
  logic        d1_i_tlast = 1'b0, d1_i_tvalid = 1'b0, d1_i_tready;
  logic [31:0] d1_o_tdata, d1_p_tdata;
  logic        d1_o_tlast, d1_o_tvalid, d1_p_tlast, d1_p_tvalid;
  logic        d1_o_tready = 1'b1, d1_p_tready = 1'b0;
  logic [7:0]  d1_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ofdm_subcarrier_demux dut (
    .clk_i(clk), .rst_ni(rst_ni), .sof_i(sof_i),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .p_tdata(p_tdata), .p_tlast(p_tlast), .p_tvalid(p_tvalid), .p_tready(p_tready),
    .err_cnt_o(err_cnt_o)
  );

  ofdm_subcarrier_demux #(.DROP_PILOTS(1'b1)) dut_drop (
    .clk_i(clk), .rst_ni(rst_ni), .sof_i(d1_sof),
    .i_tdata(d1_i_tdata), .i_tlast(d1_i_tlast), .i_tvalid(d1_i_tvalid), .i_tready(d1_i_tready),
    .o_tdata(d1_o_tdata), .o_tlast(d1_o_tlast), .o_tvalid(d1_o_tvalid), .o_tready(d1_o_tready),
    .p_tdata(d1_p_tdata), .p_tlast(d1_p_tlast), .p_tvalid(d1_p_tvalid), .p_tready(d1_p_tready),
    .err_cnt_o(d1_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: class by rule, 1-deep queues stand in for the output stages.
  function automatic int cls_of(input int i);
    if (i <= 5 || i == 32 || i >= 59) return 0;
    if (i == 11 || i == 25 || i == 39 || i == 53) return 2;
    return 1;
  endfunction

  logic [32:0] dq[$], pq[$], cap_d[$], cap_p[$];
  int m_idx = 0;
  int m_err = 0;

  always @(negedge clk) begin
    int cur, c;
    bit exp_rdy;
    if (!rst_ni) begin
      chk("rst_i_tready", i_tready, 0);
      chk("rst_o_tvalid", o_tvalid, 0);
      chk("rst_p_tvalid", p_tvalid, 0);
      chk("rst_o_data", {o_tlast, o_tdata}, 0);
      chk("rst_p_data", {p_tlast, p_tdata}, 0);
      chk("rst_err", err_cnt_o, 0);
      dq.delete(); pq.delete();
      m_idx = 0; m_err = 0;
    end else begin
      cur = sof_i ? 0 : m_idx;
      c = cls_of(cur);
      exp_rdy = (c == 0) || (c == 1 && (dq.size() == 0 || o_tready)) ||
                (c == 2 && (pq.size() == 0 || p_tready));
      chk("i_tready", i_tready, exp_rdy);
      chk("o_tvalid", o_tvalid, dq.size() != 0);
      if (dq.size() != 0) chk("o_data", {o_tlast, o_tdata}, dq[0]);
      chk("p_tvalid", p_tvalid, pq.size() != 0);
      if (pq.size() != 0) chk("p_data", {p_tlast, p_tdata}, pq[0]);
      chk("err_cnt", err_cnt_o, m_err);
      if (o_tvalid && o_tready) cap_d.push_back({o_tlast, o_tdata});
      if (p_tvalid && p_tready) cap_p.push_back({p_tlast, p_tdata});
      if (dq.size() != 0 && o_tready) void'(dq.pop_front());
      if (pq.size() != 0 && p_tready) void'(pq.pop_front());
      if (i_tvalid && exp_rdy) begin
        if (c == 1) dq.push_back({cur == 58, i_tdata});
        if (c == 2) pq.push_back({cur == 53, i_tdata});
        if ((i_tlast && cur != 63) || (!i_tlast && cur == 63))
          m_err = (m_err < 255) ? m_err + 1 : 255;
        if (i_tlast && cur != 63) m_idx = 0;
        else if (sof_i)           m_idx = 1;
        else                      m_idx = (cur + 1) % 64;
      end
    end
  end

  logic [32:0] cap1[$];
  always @(negedge clk) begin
    if (rst_ni) begin
      chk("drop_p_tvalid", d1_p_tvalid, 0);
      if (d1_o_tvalid && d1_o_tready) cap1.push_back({d1_o_tlast, d1_o_tdata});
    end
  end

  // Present one beat and hold it until accepted; returns at posedge+1.
  task automatic send_beat(input logic [31:0] d, input logic l, input logic s);
    bit got = 0;
    int n = 0;
    i_tvalid = 1'b1; i_tdata = d; i_tlast = l; sof_i = s;
    while (!got) begin
      @(negedge clk); got = i_tready;
      @(posedge clk); #1;
      n++;
      if (!got && n > 200) begin
        chk("accept_timeout", 1, 0);
        got = 1;
      end
    end
  endtask

  task automatic send_range(input int a, input int b, input int last_at);
    for (int i = a; i <= b; i++) send_beat(i, i == last_at, 1'b0);
  endtask

  task automatic idle(input int cycles);
    i_tvalid = 1'b0; i_tlast = 1'b0; sof_i = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic check_data_list(input string tag, input int off);
    int k = 0;
    int lo[6] = '{6, 12, 26, 33, 40, 54};
    int hi[6] = '{10, 24, 31, 38, 52, 58};
    for (int r = 0; r < 6; r++)
      for (int v = lo[r]; v <= hi[r]; v++) begin
        if (off + k < cap_d.size())
          chk(tag, cap_d[off + k], {v == 58, 32'(v)});
        k++;
      end
  endtask

  initial begin
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Scenario 1: full symbol, both outputs always ready.
    cap_d.delete(); cap_p.delete();
    send_range(0, 63, 63);
    idle(3);
    chk("s1_data_count", cap_d.size(), 48);
    check_data_list("s1_data_seq", 0);
    chk("s1_pilot_count", cap_p.size(), 4);
    if (cap_p.size() == 4) begin
      chk("s1_pilot0", cap_p[0], {1'b0, 32'd11});
      chk("s1_pilot1", cap_p[1], {1'b0, 32'd25});
      chk("s1_pilot2", cap_p[2], {1'b0, 32'd39});
      chk("s1_pilot3", cap_p[3], {1'b1, 32'd53});
    end

    // Scenario 2: data output blocked while a second data beat waits.
    cap_d.delete();
    o_tready = 1'b0;
    send_range(0, 6, 99);
    i_tdata = 32'd7; i_tlast = 1'b0; sof_i = 1'b0; i_tvalid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("s2_stall_ready", i_tready, 0);
      chk("s2_hold_data", {o_tvalid, o_tlast, o_tdata}, {2'b10, 32'd6});
    end
    @(posedge clk); #1;
    o_tready = 1'b1;
    send_range(7, 63, 63);
    idle(3);
    chk("s2_data_count", cap_d.size(), 48);
    check_data_list("s2_data_seq", 0);

    // Scenario 3: early tlast at index 40, then a clean symbol.
    send_range(0, 40, 40);
    idle(2);
    chk("s3_err", err_cnt_o, 1);
    cap_d.delete();
    send_range(0, 63, 63);
    idle(3);
    chk("s3_data_count", cap_d.size(), 48);
    check_data_list("s3_restart_seq", 0);

    // Scenario 4: sof mid-symbol at index 20.
    cap_d.delete();
    send_range(0, 19, 99);
    send_beat(32'd20, 1'b0, 1'b1);
    send_range(1, 63, 63);
    idle(3);
    chk("s4_err", err_cnt_o, 1);
    chk("s4_data_count", cap_d.size(), 61);
    if (cap_d.size() > 13) chk("s4_pre_sof_last", cap_d[12], {1'b0, 32'd19});
    check_data_list("s4_post_sof_seq", 13);

    // Scenario 5: DROP_PILOTS instance with pilot port blocked.
    cap1.delete();
    for (int i = 0; i < 64; i++) begin
      d1_i_tvalid = 1'b1; d1_i_tdata = i; d1_i_tlast = (i == 63);
      @(negedge clk); chk("s5_i_tready", d1_i_tready, 1);
      @(posedge clk); #1;
    end
    d1_i_tvalid = 1'b0; d1_i_tlast = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("s5_data_count", cap1.size(), 48);
    if (cap1.size() == 48) begin
      chk("s5_first", cap1[0], {1'b0, 32'd6});
      chk("s5_last", cap1[47], {1'b1, 32'd58});
    end
    chk("s5_err", d1_err, 0);

    // Scenario 6: asynchronous reset with a buffered beat, then saturation.
    o_tready = 1'b0;
    send_range(0, 6, 99);
    chk("s6_pre_valid", o_tvalid, 1);
    i_tvalid = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("s6_async_valid", o_tvalid, 0);
    chk("s6_async_data", o_tdata, 0);
    chk("s6_async_ready", i_tready, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_ni = 1'b1;
    o_tready = 1'b1;
    for (int i = 0; i < 300; i++) send_beat(32'hA000 + i, 1'b1, (i % 2) == 1);
    idle(2);
    chk("s6_err_sat", err_cnt_o, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
